// File: rtl/rst_seq_artys7.sv
// Reset sequencer for the Arty S7 system: synchronises MMCM lock and releases peripheral then core resets.
// Optional lock-loss event counter is built when RST_SEQ_LOCK_LOSS_CNT_EN is defined.
module rst_seq_artys7 #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int CORE_DELAY_CYCLES  = 16,
  parameter int SW_RST_CYCLES      = 32
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pll_locked_i,
  input  logic       sw_rst_req_i,
  output logic       rst_periph_no,
  output logic       rst_core_no,
  output logic       rst_done_o,
  output logic [2:0] state_o,
  output logic [7:0] lock_loss_cnt_o
);

  localparam int MAX_AB = (LOCK_STABLE_CYCLES > CORE_DELAY_CYCLES) ? LOCK_STABLE_CYCLES : CORE_DELAY_CYCLES;
  localparam int MAX_C  = (MAX_AB > SW_RST_CYCLES) ? MAX_AB : SW_RST_CYCLES;
  localparam int CW     = $clog2(MAX_C) + 1;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    PERIPH    = 3'd2,
    RUN       = 3'd3,
    SW_RST    = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_lock;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_nxt;
  logic                   r_periph_n;
  logic                   r_core_n;
  logic                   r_done;
  logic                   w_periph_rel;
  logic                   w_core_rel;

  assign w_lock = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked_i};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      WAIT_LOCK: begin
        if (w_lock) begin
          w_state_nxt = STABLE;
          w_cnt_nxt   = '0;
        end
      end
      STABLE: begin
        if (!w_lock) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CW'(LOCK_STABLE_CYCLES - 1)) begin
          w_state_nxt = PERIPH;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      PERIPH: begin
        if (!w_lock) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CW'(CORE_DELAY_CYCLES - 1)) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      RUN: begin
        // Lock loss outranks a software request on the same edge
        if (!w_lock) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (sw_rst_req_i) begin
          w_state_nxt = SW_RST;
          w_cnt_nxt   = '0;
        end
      end
      SW_RST: begin
        if (!w_lock) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CW'(SW_RST_CYCLES - 1)) begin
          w_state_nxt = PERIPH;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = WAIT_LOCK;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Reset outputs follow the next state so they change on the same edge as the state
  assign w_periph_rel = (w_state_nxt == PERIPH) || (w_state_nxt == RUN);
  assign w_core_rel   = (w_state_nxt == RUN);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= WAIT_LOCK;
      r_cnt      <= '0;
      r_periph_n <= 1'b0;
      r_core_n   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_periph_n <= w_periph_rel;
      r_core_n   <= w_core_rel;
      r_done     <= w_core_rel;
    end
  end

  assign rst_periph_no = r_periph_n;
  assign rst_core_no   = r_core_n;
  assign rst_done_o    = r_done;
  assign state_o       = r_state;

`ifdef RST_SEQ_LOCK_LOSS_CNT_EN
  logic       w_lock_loss;
  logic [7:0] r_llc;

  assign w_lock_loss = !w_lock && ((r_state == PERIPH) || (r_state == RUN) || (r_state == SW_RST));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_llc <= 8'h00;
    end else if (w_lock_loss && (r_llc != 8'hFF)) begin
      r_llc <= r_llc + 8'd1;
    end
  end

  assign lock_loss_cnt_o = r_llc;
`else
  assign lock_loss_cnt_o = 8'h00;
`endif

endmodule

// File: tb/tb_rst_seq_artys7.sv
// Bench for rst_seq_artys7: directed sequence timing plus random lock/sw-request traffic against a timestamp model.
module tb_rst_seq_artys7;
  localparam int SS = 2;
  localparam int LS = 8;
  localparam int CD = 4;
  localparam int SW = 6;
`ifdef RST_SEQ_LOCK_LOSS_CNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll;
  logic       sw;
  logic       periph_n;
  logic       core_n;
  logic       done;
  logic [2:0] state;
  logic [7:0] llc;

  always #5 clk = ~clk;

  rst_seq_artys7 #(
    .SYNC_STAGES       (SS),
    .LOCK_STABLE_CYCLES(LS),
    .CORE_DELAY_CYCLES (CD),
    .SW_RST_CYCLES     (SW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .pll_locked_i   (pll),
    .sw_rst_req_i   (sw),
    .rst_periph_no  (periph_n),
    .rst_core_no    (core_n),
    .rst_done_o     (done),
    .state_o        (state),
    .lock_loss_cnt_o(llc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: the sequence is described by the edge numbers at which each reset is due to release.
  int now_e = 0;
  bit m_seq;
  bit m_sw;
  int m_stable_end;
  int m_periph_at;
  int m_core_at;
  int m_llc;
  bit sq[$];

  function automatic void model_reset();
    sq.delete();
    for (int i = 0; i < SS; i++) sq.push_back(1'b0);
    m_seq = 1'b0;
    m_sw  = 1'b0;
    m_llc = 0;
  endfunction

  function automatic void model_edge(input bit pll_s, input bit sw_s);
    bit ls;
    now_e++;
    ls = sq.pop_front();
    sq.push_back(pll_s);
    if (!m_seq) begin
      if (ls) begin
        m_seq        = 1'b1;
        m_sw         = 1'b0;
        m_stable_end = now_e + LS;
        m_periph_at  = now_e + LS;
        m_core_at    = m_periph_at + CD;
      end
    end else if (!ls) begin
      if (now_e > m_stable_end && m_llc < 255) m_llc++;
      m_seq = 1'b0;
    end else if (sw_s && now_e > m_core_at) begin
      m_sw        = 1'b1;
      m_periph_at = now_e + SW;
      m_core_at   = m_periph_at + CD;
    end
  endfunction

  task automatic check_outs();
    bit       e_p, e_c;
    int       e_st;
    int       e_llc;
    e_p   = m_seq && (now_e >= m_periph_at);
    e_c   = m_seq && (now_e >= m_core_at);
    e_st  = !m_seq ? 0 : (now_e < m_periph_at) ? (m_sw ? 4 : 1) : (now_e < m_core_at) ? 2 : 3;
    e_llc = (CNT_EN != 0) ? m_llc : 0;
    chk("outs", 32'({periph_n, core_n, done, state, llc}),
        32'({e_p, e_c, e_c, e_st[2:0], e_llc[7:0]}));
    chk("core_before_periph", 32'(core_n & ~periph_n), 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge(pll, sw);
    #1;
    check_outs();
  endtask

  // which: 0 = peripheral released, 1 = core released, 2 = peripheral reasserted
  task automatic run_until(input int which, input int limit, input int start, output int n);
    bit hit;
    hit = 1'b0;
    n   = start;
    while (!hit && n < start + limit) begin
      step();
      n++;
      case (which)
        0:       hit = periph_n;
        1:       hit = core_n;
        default: hit = !periph_n;
      endcase
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pll   = 1'b0;
    sw    = 1'b0;
    model_reset();
    #1;
    check_outs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  int n;

  initial begin
    rst_n = 1'b1;
    pll   = 1'b0;
    sw    = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    check_outs();
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_periph", 32'(periph_n), 32'd0);
    step();
    step();
    rst_n = 1'b1;

    pll = 1'b1;
    run_until(0, 40, 0, n);
    chk("pu_periph_edge", n, 11);
    run_until(1, 40, n, n);
    chk("pu_core_edge", n, 15);
    chk("pu_state", 32'(state), 32'd3);
    chk("pu_done", 32'(done), 32'd1);

    do_reset();
    pll = 1'b1;
    repeat (5) step();
    pll = 1'b0;
    step();
    pll = 1'b1;
    run_until(0, 40, 0, n);
    chk("glitch_periph_edge", n, 11);
    run_until(1, 40, n, n);
    chk("glitch_core_edge", n, 15);

    sw = 1'b1;
    step();
    sw = 1'b0;
    chk("sw_periph_low", 32'(periph_n), 32'd0);
    chk("sw_core_low", 32'(core_n), 32'd0);
    chk("sw_state", 32'(state), 32'd4);
    run_until(0, 40, 0, n);
    chk("sw_periph_edge", n, 6);
    run_until(1, 40, n, n);
    chk("sw_core_edge", n, 10);

    pll = 1'b0;
    run_until(2, 40, 0, n);
    chk("ll_edge", n, 3);
    chk("ll_core", 32'(core_n), 32'd0);
    chk("ll_done", 32'(done), 32'd0);
    chk("ll_state", 32'(state), 32'd0);
    chk("ll_cnt", 32'(llc), 32'(CNT_EN));

    pll = 1'b1;
    run_until(0, 40, 0, n);
    chk("ap_periph_edge", n, 11);
    #2 rst_n = 1'b0;
    #1;
    chk("ap_periph_async", 32'(periph_n), 32'd0);
    chk("ap_core_async", 32'(core_n), 32'd0);
    chk("ap_state_async", 32'(state), 32'd0);
    model_reset();
    rst_n = 1'b1;
    run_until(0, 40, 0, n);
    chk("ap_replay_periph", n, 11);
    run_until(1, 40, n, n);
    chk("ap_replay_core", n, 15);

    pll = 1'b0;
    step();
    step();
    sw = 1'b1;
    step();
    sw = 1'b0;
    chk("sim_state", 32'(state), 32'd0);
    step();
    chk("sim_state_after", 32'(state), 32'd0);

    repeat (120) begin
      bit v;
      int len;
      v   = ($urandom_range(0, 3) != 0);
      len = $urandom_range(1, 30);
      repeat (len) begin
        pll = v;
        sw  = ($urandom_range(0, 15) == 0);
        step();
      end
    end
    sw = 1'b0;

    for (int i = 0; i < 300; i++) begin
      pll = 1'b1;
      repeat (14) step();
      pll = 1'b0;
      repeat (4) step();
    end
    chk("sat_cnt", 32'(llc), 32'((CNT_EN != 0) ? 255 : 0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
